// File: rtl/seg_map_ctrl_pkg.sv
// Shared types and constants for the segment-map controller.
package seg_map_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT_MAP,
        INIT_EMS,
        IDLE,
        WRITE,
        READ,
        ACK,
        DONE
    } state_t;

    localparam int unsigned MAP_COUNT = 16;
    localparam int unsigned EMS_COUNT = 4;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned DATA_W    = 8;

    localparam logic [15:0] MAP_BASE_DEF = 16'h0080;
    localparam logic [15:0] EMS_BASE_DEF = 16'h0208;

    // EMS pages come up unmapped
    localparam logic [DATA_W-1:0] EMS_INIT_DATA = 8'hFF;

endpackage

// File: rtl/seg_map_port_dec.sv
// I/O port decoder: classifies an address as map port, EMS port or miss.
module seg_map_port_dec
    import seg_map_ctrl_pkg::*;
#(
    parameter logic [15:0] MAP_BASE = MAP_BASE_DEF,
    parameter logic [15:0] EMS_BASE = EMS_BASE_DEF,
    parameter bit          EMS_EN   = 1'b1
) (
    input  logic [15:0]      io_addr,
    output logic             hit,
    output logic             is_ems,
    output logic [IDX_W-1:0] index
);

    logic [15:0] map_off;
    logic [15:0] ems_off;
    logic        map_hit;
    logic        ems_hit;

    assign map_off = io_addr - MAP_BASE;
    assign ems_off = io_addr - EMS_BASE;
    assign map_hit = (map_off < 16'(MAP_COUNT));
    assign ems_hit = EMS_EN && (ems_off < 16'(EMS_COUNT));

    // Map window takes priority should the two windows ever overlap
    assign hit    = map_hit | ems_hit;
    assign is_ems = !map_hit && ems_hit;
    assign index  = is_ems ? {2'b00, io_addr[1:0]} : io_addr[3:0];

endmodule

// File: rtl/seg_map_ctrl.sv
// Segment-map register controller: power-up init of map/EMS registers and
// single-beat CPU I/O access with a one-cycle acknowledge.
module seg_map_ctrl
    import seg_map_ctrl_pkg::*;
#(
    parameter logic [15:0] MAP_BASE = MAP_BASE_DEF,
    parameter logic [15:0] EMS_BASE = EMS_BASE_DEF,
    parameter bit          EMS_EN   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [15:0]       IO_ADDR,
    input  logic [DATA_W-1:0] IO_WDATA,
    input  logic              IO_WR,
    input  logic              IO_RD,
    output logic [DATA_W-1:0] IO_RDATA,
    output logic              IO_ACK,
    output logic              HIT,
    output logic              BUSY,
    output logic [IDX_W-1:0]  SM_ADDR,
    output logic [DATA_W-1:0] SM_WDATA,
    input  logic [DATA_W-1:0] SM_RDATA,
    output logic              SM_WE,
    output logic              SM_WE_EMS,
    output logic              SM_EMS_OE
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             is_ems;
    logic             dec_is_ems;
    logic [IDX_W-1:0] dec_index;

    seg_map_port_dec #(
        .MAP_BASE (MAP_BASE),
        .EMS_BASE (EMS_BASE),
        .EMS_EN   (EMS_EN)
    ) u_dec (
        .io_addr (IO_ADDR),
        .hit     (HIT),
        .is_ems  (dec_is_ems),
        .index   (dec_index)
    );

    // Read-path select is a pure decode of registered state, so it is glitch-free
    assign SM_EMS_OE = (state == READ) && is_ems;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= INIT_MAP;
            idx       <= '0;
            is_ems    <= 1'b0;
            BUSY      <= 1'b1;
            SM_WE     <= 1'b0;
            SM_WE_EMS <= 1'b0;
            IO_ACK    <= 1'b0;
            SM_ADDR   <= '0;
            SM_WDATA  <= '0;
            IO_RDATA  <= '0;
        end else begin
            SM_WE     <= 1'b0;
            SM_WE_EMS <= 1'b0;
            IO_ACK    <= 1'b0;

            case (state)
                INIT_MAP: begin
                    SM_WE    <= 1'b1;
                    SM_ADDR  <= idx;
                    SM_WDATA <= {4'h0, idx};
                    if (idx == IDX_W'(MAP_COUNT - 1)) begin
                        idx <= '0;
                        if (EMS_EN) begin
                            state <= INIT_EMS;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                INIT_EMS: begin
                    SM_WE_EMS <= 1'b1;
                    SM_ADDR   <= {2'b00, idx[1:0]};
                    SM_WDATA  <= EMS_INIT_DATA;
                    if (idx == IDX_W'(EMS_COUNT - 1)) begin
                        idx   <= '0;
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                // Write wins when both requests are present
                IDLE: begin
                    if (HIT && (IO_WR || IO_RD)) begin
                        SM_ADDR  <= dec_index;
                        SM_WDATA <= IO_WDATA;
                        is_ems   <= dec_is_ems;
                        if (IO_WR) begin
                            state     <= WRITE;
                            SM_WE     <= !dec_is_ems;
                            SM_WE_EMS <= dec_is_ems;
                        end else begin
                            state <= READ;
                        end
                    end
                end

                WRITE: begin
                    IO_ACK <= 1'b1;
                    state  <= ACK;
                end

                READ: begin
                    IO_RDATA <= SM_RDATA;
                    IO_ACK   <= 1'b1;
                    state    <= ACK;
                end

                ACK: begin
                    state <= DONE;
                end

                // Hold off until the CPU drops its request so it is serviced once
                DONE: begin
                    if (!IO_WR && !IO_RD) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_map_ctrl.sv
// Directed self-checking bench for seg_map_ctrl.
module tb_seg_map_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] IO_ADDR;
    logic [7:0]  IO_WDATA;
    logic        IO_WR;
    logic        IO_RD;
    logic [7:0]  SM_RDATA;

    logic [7:0]  IO_RDATA;
    logic        IO_ACK;
    logic        HIT;
    logic        BUSY;
    logic [3:0]  SM_ADDR;
    logic [7:0]  SM_WDATA;
    logic        SM_WE;
    logic        SM_WE_EMS;
    logic        SM_EMS_OE;

    logic [7:0]  n_io_rdata;
    logic        n_io_ack;
    logic        n_hit;
    logic        n_busy;
    logic [3:0]  n_sm_addr;
    logic [7:0]  n_sm_wdata;
    logic        n_sm_we;
    logic        n_sm_we_ems;
    logic        n_sm_ems_oe;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    seg_map_ctrl dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IO_ADDR   (IO_ADDR),
        .IO_WDATA  (IO_WDATA),
        .IO_WR     (IO_WR),
        .IO_RD     (IO_RD),
        .IO_RDATA  (IO_RDATA),
        .IO_ACK    (IO_ACK),
        .HIT       (HIT),
        .BUSY      (BUSY),
        .SM_ADDR   (SM_ADDR),
        .SM_WDATA  (SM_WDATA),
        .SM_RDATA  (SM_RDATA),
        .SM_WE     (SM_WE),
        .SM_WE_EMS (SM_WE_EMS),
        .SM_EMS_OE (SM_EMS_OE)
    );

    seg_map_ctrl #(.EMS_EN(1'b0)) dut_noems (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IO_ADDR   (IO_ADDR),
        .IO_WDATA  (IO_WDATA),
        .IO_WR     (IO_WR),
        .IO_RD     (IO_RD),
        .IO_RDATA  (n_io_rdata),
        .IO_ACK    (n_io_ack),
        .HIT       (n_hit),
        .BUSY      (n_busy),
        .SM_ADDR   (n_sm_addr),
        .SM_WDATA  (n_sm_wdata),
        .SM_RDATA  (SM_RDATA),
        .SM_WE     (n_sm_we),
        .SM_WE_EMS (n_sm_we_ems),
        .SM_EMS_OE (n_sm_ems_oe)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 16'({SM_WE, SM_WE_EMS, SM_EMS_OE, IO_ACK}), 16'h0);
    endtask

    initial begin
        RST_N    = 1'b0;
        IO_ADDR  = 16'h0000;
        IO_WDATA = 8'h00;
        IO_WR    = 1'b0;
        IO_RD    = 1'b0;
        SM_RDATA = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_busy",     16'(BUSY),      16'h1);
        chk("rst_we",       16'(SM_WE),     16'h0);
        chk("rst_we_ems",   16'(SM_WE_EMS), 16'h0);
        chk("rst_ack",      16'(IO_ACK),    16'h0);
        chk("rst_ems_oe",   16'(SM_EMS_OE), 16'h0);
        chk("rst_addr",     16'(SM_ADDR),   16'h0);
        chk("rst_wdata",    16'(SM_WDATA),  16'h0);
        chk("rst_rdata",    16'(IO_RDATA),  16'h0);

        // Init sequence: 16 identity map writes, then 4 EMS writes of FF
        RST_N = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 16) begin
                chk("init_map_we",    16'(SM_WE),     16'h1);
                chk("init_map_weems", 16'(SM_WE_EMS), 16'h0);
                chk("init_map_addr",  16'(SM_ADDR),   16'(k - 1));
                chk("init_map_wdata", 16'(SM_WDATA),  16'(k - 1));
            end else begin
                chk("init_ems_we",    16'(SM_WE_EMS), 16'h1);
                chk("init_ems_mapwe", 16'(SM_WE),     16'h0);
                chk("init_ems_addr",  16'(SM_ADDR),   16'(k - 17));
                chk("init_ems_wdata", 16'(SM_WDATA),  16'h00FF);
            end
            chk("init_busy", 16'(BUSY), (k < 20) ? 16'h1 : 16'h0);
            if (k == 16) chk("noems_busy", 16'(n_busy), 16'h0);
            if (k == 17) chk("noems_no_ems_init", 16'({n_sm_we, n_sm_we_ems}), 16'h0);
        end
        tick();
        chk_quiet("post_init_quiet");

        // Map write 0x0085 <- 0x12
        IO_ADDR  = 16'h0085;
        IO_WDATA = 8'h12;
        IO_WR    = 1'b1;
        #1;
        chk("wr_hit", 16'(HIT), 16'h1);
        tick();
        chk("wr_we",     16'(SM_WE),     16'h1);
        chk("wr_weems",  16'(SM_WE_EMS), 16'h0);
        chk("wr_addr",   16'(SM_ADDR),   16'h5);
        chk("wr_wdata",  16'(SM_WDATA),  16'h12);
        chk("wr_ack_c1", 16'(IO_ACK),    16'h0);
        tick();
        chk("wr_we_off", 16'(SM_WE),     16'h0);
        chk("wr_ack",    16'(IO_ACK),    16'h1);
        tick();
        chk("wr_ack_off", 16'(IO_ACK),   16'h0);
        IO_WR = 1'b0;
        tick();

        // EMS read 0x020A, map returns 0x07
        IO_ADDR  = 16'h020A;
        IO_RD    = 1'b1;
        SM_RDATA = 8'h07;
        #1;
        chk("ems_rd_hit", 16'(HIT), 16'h1);
        tick();
        chk("ems_rd_oe",   16'(SM_EMS_OE), 16'h1);
        chk("ems_rd_addr", 16'(SM_ADDR),   16'h2);
        chk("ems_rd_ack0", 16'(IO_ACK),    16'h0);
        chk("ems_rd_nowe", 16'({SM_WE, SM_WE_EMS}), 16'h0);
        tick();
        chk("ems_rd_oe_off", 16'(SM_EMS_OE), 16'h0);
        chk("ems_rd_ack",    16'(IO_ACK),    16'h1);
        chk("ems_rd_data",   16'(IO_RDATA),  16'h07);
        IO_RD    = 1'b0;
        SM_RDATA = 8'h55;
        tick();
        chk("rdata_hold", 16'(IO_RDATA), 16'h07);
        chk("ems_rd_ack_off", 16'(IO_ACK), 16'h0);
        tick();

        // Map read of the top entry 0x008F
        IO_ADDR  = 16'h008F;
        IO_RD    = 1'b1;
        SM_RDATA = 8'h3C;
        tick();
        chk("map_rd_oe",   16'(SM_EMS_OE), 16'h0);
        chk("map_rd_addr", 16'(SM_ADDR),   16'hF);
        tick();
        chk("map_rd_ack",  16'(IO_ACK),    16'h1);
        chk("map_rd_data", 16'(IO_RDATA),  16'h3C);
        IO_RD = 1'b0;
        tick();
        tick();

        // Write and read together: write wins, held request serviced once
        IO_ADDR  = 16'h0080;
        IO_WDATA = 8'hA5;
        IO_WR    = 1'b1;
        IO_RD    = 1'b1;
        tick();
        chk("both_we",    16'(SM_WE),     16'h1);
        chk("both_oe",    16'(SM_EMS_OE), 16'h0);
        chk("both_addr",  16'(SM_ADDR),   16'h0);
        chk("both_wdata", 16'(SM_WDATA),  16'hA5);
        tick();
        chk("both_ack", 16'(IO_ACK), 16'h1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_quiet("held_no_repeat");
        end
        IO_WR = 1'b0;
        IO_RD = 1'b0;
        tick();

        // Miss address
        IO_ADDR  = 16'h0300;
        IO_WDATA = 8'h44;
        IO_WR    = 1'b1;
        #1;
        chk("miss_hit", 16'(HIT), 16'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_quiet("miss_quiet");
        end

        // EMS write: passes through on the EMS build, ignored without EMS
        IO_ADDR  = 16'h0208;
        IO_WDATA = 8'h3A;
        #1;
        chk("ems_hit",       16'(HIT),   16'h1);
        chk("noems_ems_hit", 16'(n_hit), 16'h0);
        tick();
        chk("ems_wr_weems", 16'(SM_WE_EMS), 16'h1);
        chk("ems_wr_we",    16'(SM_WE),     16'h0);
        chk("ems_wr_addr",  16'(SM_ADDR),   16'h0);
        chk("ems_wr_wdata", 16'(SM_WDATA),  16'h3A);
        chk("noems_wr_strobe", 16'({n_sm_we, n_sm_we_ems}), 16'h0);
        tick();
        chk("ems_wr_ack",   16'(IO_ACK),   16'h1);
        chk("noems_wr_ack", 16'(n_io_ack), 16'h0);
        IO_WR = 1'b0;
        tick();
        tick();

        // Reset during init: restart from index 0
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("midinit_addr7", 16'(SM_ADDR), 16'h7);
        RST_N = 1'b0;
        tick();
        chk("midinit_rst_we",   16'(SM_WE),   16'h0);
        chk("midinit_rst_busy", 16'(BUSY),    16'h1);
        chk("midinit_rst_addr", 16'(SM_ADDR), 16'h0);
        RST_N = 1'b1;
        tick();
        chk("midinit_restart_we",   16'(SM_WE),   16'h1);
        chk("midinit_restart_addr", 16'(SM_ADDR), 16'h0);
        for (int k = 0; k < 19; k++) tick();
        chk("reinit_last_weems", 16'(SM_WE_EMS), 16'h1);
        chk("reinit_last_addr",  16'(SM_ADDR),   16'h3);
        chk("reinit_busy",       16'(BUSY),      16'h0);
        tick();

        // Reset during WRITE: no ACK, init restarts
        IO_ADDR  = 16'h0087;
        IO_WDATA = 8'h99;
        IO_WR    = 1'b1;
        tick();
        chk("wrrst_we",   16'(SM_WE),    16'h1);
        chk("wrrst_addr", 16'(SM_ADDR),  16'h7);
        RST_N = 1'b0;
        IO_WR = 1'b0;
        tick();
        chk_quiet("wrrst_abort");
        chk("wrrst_busy", 16'(BUSY), 16'h1);
        tick();
        chk("wrrst_no_ack", 16'(IO_ACK), 16'h0);
        RST_N = 1'b1;
        tick();
        chk("wrrst_restart_we",    16'(SM_WE),    16'h1);
        chk("wrrst_restart_addr",  16'(SM_ADDR),  16'h0);
        chk("wrrst_restart_wdata", 16'(SM_WDATA), 16'h0);
        chk("wrrst_restart_ack",   16'(IO_ACK),   16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_map_ctrl.md
SEG_MAP_CTRL -- requirements
Module: seg_map_ctrl

Interface
REQ-001 SHALL have parameter MAP_BASE, default 16'h0080, I/O base of the 16 segment-map registers (MAP_BASE..MAP_BASE+15).
REQ-002 SHALL have parameter EMS_BASE, default 16'h0208, I/O base of the 4 EMS page registers (EMS_BASE..EMS_BASE+3).
REQ-003 SHALL have parameter EMS_EN, default 1, enable for EMS port decode (0 = EMS ports never hit).
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
  CLK  in  1  single system clock, all logic rising-edge.
  RST_N  in  1  synchronous, active-low reset.
  IO_ADDR  in  16  CPU I/O port address.
  IO_WDATA  in  8  CPU I/O write data.
  IO_WR  in  1  level write request, held until IO_ACK.
  IO_RD  in  1  level read request, held until IO_ACK.
  IO_RDATA  out  8  read data, valid in the IO_ACK cycle.
  IO_ACK  out  1  one-cycle completion pulse.
  HIT  out  1  combinational: IO_ADDR decodes to a map or enabled EMS port.
  BUSY  out  1  high while the init sequence runs.
  SM_ADDR  out  4  segment-map register index.
  SM_WDATA  out  8  segment-map write data.
  SM_RDATA  in  8  segment-map read data (combinational from map).
  SM_WE  out  1  map-register write strobe.
  SM_WE_EMS  out  1  EMS-register write strobe.
  SM_EMS_OE  out  1  selects EMS read path on SM_RDATA.

Function
REQ-005 SHALL implement FSM states INIT_MAP, INIT_EMS, IDLE, WRITE, READ, ACK, DONE.
REQ-006 INIT_MAP SHALL write entry i with data i (identity map), i = 0..15, one SM_WE pulse per cycle, 16 cycles, then go to INIT_EMS.
REQ-007 INIT_EMS SHALL write 8'hFF to EMS index 0..3, one SM_WE_EMS pulse per cycle, 4 cycles, then go to IDLE; skipped (direct to IDLE) when EMS_EN=0.
REQ-008 BUSY SHALL be 1 in INIT_MAP/INIT_EMS, else 0; requests SHALL NOT be accepted while BUSY.
REQ-009 In IDLE, IO_WR with HIT SHALL go to WRITE; else IO_RD with HIT SHALL go to READ; write wins when both asserted.
REQ-010 Requests without HIT SHALL be ignored: no strobe, no IO_ACK, state stays IDLE.
REQ-011 On acceptance, SM_ADDR (IO_ADDR[3:0] for map, {2'b00, IO_ADDR[1:0]} for EMS), SM_WDATA and an internal is_ems flag SHALL be registered.
REQ-012 WRITE SHALL assert exactly one of SM_WE/SM_WE_EMS for exactly one cycle, then go to ACK.
REQ-013 READ SHALL drive SM_EMS_OE = is_ems for one cycle, capture SM_RDATA into IO_RDATA at the end of that cycle, then go to ACK.
REQ-014 ACK SHALL pulse IO_ACK for one cycle; IO_RDATA SHALL hold its last value until the next read capture.
REQ-015 Latency: IO_ACK SHALL assert exactly 2 cycles after the accepting IDLE cycle, for both reads and writes.
REQ-016 DONE SHALL wait until IO_WR=0 and IO_RD=0, then go to IDLE, so one held request is never serviced twice.
REQ-017 SM_WE, SM_WE_EMS and IO_ACK SHALL never be asserted in the same cycle; SM_EMS_OE SHALL be 0 outside READ.
REQ-018 EMS port write data SHALL pass through unchanged; value filtering is done by the map.

Reset
REQ-019 While RST_N=0 at a clock edge: state SHALL be INIT_MAP with index 0, and all strobes, IO_ACK, SM_EMS_OE, SM_ADDR, SM_WDATA and IO_RDATA SHALL be 0; BUSY SHALL be 1.
REQ-020 Reset asserted mid-operation (any state, including mid-init) SHALL abort the operation without completing a strobe or IO_ACK and SHALL restart init from index 0.

Structure
REQ-021 Package seg_map_ctrl_pkg SHALL hold the FSM state enum, MAP_COUNT=16, EMS_COUNT=4 and the default base constants.
REQ-022 The port decoder SHALL be a sub-module seg_map_port_dec (IO_ADDR -> hit, is_ems, index); all other logic SHALL be in seg_map_ctrl.

Verification
REQ-023 Reset release -> 16 SM_WE pulses with SM_ADDR=SM_WDATA=0..15, then 4 SM_WE_EMS pulses with SM_WDATA=FF; BUSY falls at cycle 20.
REQ-024 IO_WR to 16'h0085, data 8'h12 -> SM_WE one cycle with SM_ADDR=5, SM_WDATA=12; IO_ACK 2 cycles after acceptance.
REQ-025 IO_RD from 16'h020A with SM_RDATA=8'h07 -> SM_EMS_OE one cycle, SM_ADDR=2, IO_RDATA=07 with IO_ACK.
REQ-026 IO_WR and IO_RD both high to 16'h0080 -> write only; request held 10 cycles after ACK -> no second strobe.
REQ-027 IO_WR to 16'h0300, and with EMS_EN=0 to 16'h0208 -> HIT=0, no strobe, no IO_ACK.
REQ-028 RST_N low during cycle 8 of init, and again during WRITE -> no further strobe or IO_ACK; init restarts at index 0.
